pw_entry_driver: RTL

//  Initiator side of the password-lock character interface: replaces the PMOD switches and enter button.

---
 rtl/pw_pkg.sv | 23 ++
 rtl/pw_cycle_timer.sv | 27 ++
 rtl/pw_entry_driver.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pw_pkg.sv
// Shared constants and types for the password-lock entry driver.
// Holds the state encoding and a helper for sizing the shared cycle timer.
package pw_pkg;

    localparam int CHAR_W_DEF = 8;
    localparam int ATTEMPTS_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StEnter,
        StGap,
        StWaitResp,
        StDone
    } pw_drv_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pw_cycle_timer.sv
// Loadable down-counter shared by every timed phase of the entry driver.
// o_expired is high while the count sits at zero; loading N-1 gives an N-cycle phase.
module pw_cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/pw_entry_driver.sv
// Initiator for the password-lock character interface: presents a latched guess one character
// at a time with an enter strobe per character, then captures and reports the lock's response.
module pw_entry_driver
    import pw_pkg::*;
#(
    parameter int PW_LEN       = 4,
    parameter int CHAR_W       = CHAR_W_DEF,
    parameter int SETUP_CYC    = 4,
    parameter int ENTER_CYC    = 2,
    parameter int RESP_TIMEOUT = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_start,
    input  logic [PW_LEN*CHAR_W-1:0] i_guess,
    output logic [CHAR_W-1:0]        o_char_out,
    output logic                     o_enter_out,
    input  logic                     i_open_in,
    input  logic                     i_wrong_in,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_result_open,
    output logic                     o_result_wrong,
    output logic                     o_result_early,
    output logic                     o_timeout,
    output logic [ATTEMPTS_W-1:0]    o_attempts
);

    localparam int TMR_MAX = max3(SETUP_CYC, ENTER_CYC, RESP_TIMEOUT);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int IDX_W   = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;

    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] ENTER_LD = TMR_W'(ENTER_CYC - 1);
    localparam logic [TMR_W-1:0] RESP_LD  = TMR_W'(RESP_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PW_LEN - 1);

    if (PW_LEN < 1 || SETUP_CYC < 1 || ENTER_CYC < 1 || RESP_TIMEOUT < 1) begin : g_bad_params
        $error("pw_entry_driver: PW_LEN and all timing parameters must be >= 1");
    end

    pw_drv_state_t             r_state;
    logic [PW_LEN*CHAR_W-1:0]  r_guess;
    logic [IDX_W-1:0]          r_idx;
    logic [CHAR_W-1:0]         r_char;
    logic                      r_enter;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_res_open;
    logic                      r_res_wrong;
    logic                      r_res_early;
    logic                      r_timeout;
    logic [ATTEMPTS_W-1:0]     r_attempts;

    logic                      w_resp;
    logic                      w_driving;
    logic                      w_tmr_load;
    logic [TMR_W-1:0]          w_tmr_val;
    logic                      w_tmr_expired;
    logic [IDX_W-1:0]          w_next_idx;
    logic [CHAR_W-1:0]         w_next_char;

    assign w_resp      = i_open_in | i_wrong_in;
    assign w_driving   = (r_state == StSetup) || (r_state == StEnter) || (r_state == StGap);
    assign w_next_idx  = r_idx + 1'b1;
    assign w_next_char = r_guess[int'(w_next_idx) * CHAR_W +: CHAR_W];

    // Reload the timer on every transition into a timed phase.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = SETUP_LD;
                end
            end
            StSetup: begin
                if (!w_resp && w_tmr_expired) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = ENTER_LD;
                end
            end
            StEnter: begin
                if (!w_resp && w_tmr_expired) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = SETUP_LD;
                end
            end
            StGap: begin
                if (!w_resp && w_tmr_expired) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = (r_idx == LAST_IDX) ? RESP_LD : SETUP_LD;
                end
            end
            default: ;
        endcase
    end

    pw_cycle_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expired  (w_tmr_expired)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= StIdle;
            r_guess     <= '0;
            r_idx       <= '0;
            r_char      <= '0;
            r_enter     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_res_open  <= 1'b0;
            r_res_wrong <= 1'b0;
            r_res_early <= 1'b0;
            r_timeout   <= 1'b0;
            r_attempts  <= '0;
        end else begin
            r_done <= 1'b0;
            // A response while characters are still going out is the fault signature.
            if (w_resp && w_driving) begin
                r_res_open  <= i_open_in;
                r_res_wrong <= i_wrong_in;
                r_res_early <= 1'b1;
                r_enter     <= 1'b0;
                r_done      <= 1'b1;
                r_state     <= StDone;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (i_start) begin
                            r_guess     <= i_guess;
                            r_idx       <= '0;
                            r_char      <= i_guess[CHAR_W-1:0];
                            r_res_open  <= 1'b0;
                            r_res_wrong <= 1'b0;
                            r_res_early <= 1'b0;
                            r_timeout   <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= StSetup;
                        end
                    end
                    StSetup: begin
                        if (w_tmr_expired) begin
                            r_enter <= 1'b1;
                            r_state <= StEnter;
                        end
                    end
                    StEnter: begin
                        if (w_tmr_expired) begin
                            r_enter <= 1'b0;
                            r_state <= StGap;
                        end
                    end
                    StGap: begin
                        if (w_tmr_expired) begin
                            if (r_idx == LAST_IDX) begin
                                r_state <= StWaitResp;
                            end else begin
                                r_idx   <= w_next_idx;
                                r_char  <= w_next_char;
                                r_state <= StSetup;
                            end
                        end
                    end
                    StWaitResp: begin
                        if (w_resp) begin
                            r_res_open  <= i_open_in;
                            r_res_wrong <= i_wrong_in;
                            r_done      <= 1'b1;
                            r_state     <= StDone;
                        end else if (w_tmr_expired) begin
                            r_timeout <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= StDone;
                        end
                    end
                    StDone: begin
                        r_busy <= 1'b0;
                        if (r_attempts != '1) begin
                            r_attempts <= r_attempts + 1'b1;
                        end
                        r_state <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_char_out     = r_char;
    assign o_enter_out    = r_enter;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_result_open  = r_res_open;
    assign o_result_wrong = r_res_wrong;
    assign o_result_early = r_res_early;
    assign o_timeout      = r_timeout;
    assign o_attempts     = r_attempts;

endmodule
